dout_emulator: RTL and testbench
================================

Name: dout_emulator

Overview:
- Transmitter end of the 4-lane ADC data-output interface (drdy, dclk, din0..din3) that the ADC front-end reader consumes.
- Serialises eight 24-bit channel samples into one framed burst per start_i pulse.
- Used for hardware-in-the-loop and loopback testing of the shear/pointing/reference acquisition chain without a physical ADC.
- Sits on the same clk_i domain. Its outputs drive PMOD pins, or the reader's inputs directly in loopback.

Parameters:
- HALF_DIV, 4, clk_i cycles per dclk half-period (dclk = clk_i / (2*HALF_DIV)); legal range >= 1.
- SLOT_BITS, 32, bits per channel slot: 8-bit header followed by 24-bit sample. Fixed at 32.

Ports:
- clk_i  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start_i  in  1  one-cycle frame request; ch*_i are captured on acceptance
- ch1_i..ch8_i  in  24 each  signed samples, two's complement
- dclk_o  out  1  free-running serial clock
- drdy_o  out  1  frame marker, high during the first bit period
- din0_o..din3_o  out  1 each  serial data lanes, MSB first
- busy_o  out  1  high from start acceptance until the frame ends
- done_o  out  1  one-cycle pulse when the frame ends
- overrun_o  out  1  one-cycle pulse when start_i is rejected

Behaviour:
- Clock and reset: reset is synchronous, active-high; clock is clk_i.
- Reset values:
  - dclk_o, drdy_o, din*_o, busy_o, done_o, overrun_o are all 0.
  - Divider count is 0, bit counter is 0, state is IDLE.
- Clock divider:
  - cnt runs 0..HALF_DIV-1 and wraps. dclk_o toggles on the cycle where cnt==HALF_DIV-1.
  - FALL event = (dclk_o==1 && cnt==HALF_DIV-1). dclk_o is 0 from the next cycle.
  - dclk runs continuously, including while IDLE.
- Lane mapping: lane0 carries ch1 then ch2; lane1 carries ch3, ch4; lane2 carries ch5, ch6; lane3 carries ch7, ch8.
- Slot format: {5'b00000, idx[2:0], sample[23:0]}, where idx = channel number - 1. Bit 31 is sent first. Each lane is 64 bits per frame.
- Output timing: all outputs are registered. din/drdy change only on FALL events, so they are stable across the following dclk rising edge.
- State machine:
  - IDLE:
    - start_i=1: capture ch1..ch8 into 64-bit lane shift registers, set busy_o=1, go to ARMED.
  - ARMED, on FALL:
    - Drive bit 63 of each lane onto din*_o and set drdy_o=1.
    - Set bit_cnt=0 and go to SHIFT.
  - SHIFT, on FALL:
    - If bit_cnt<63: shift left, present the next bit, drdy_o=0, bit_cnt++.
    - If bit_cnt==63: din*_o=0, drdy_o=0, busy_o=0, done_o=1 for one cycle, go to IDLE.
- Latency: start accept to drdy_o rise is between 1 and 2*HALF_DIV clk cycles. drdy_o is high for exactly 2*HALF_DIV cycles. One frame is 64*2*HALF_DIV cycles from drdy rise to the done_o cycle (512 at default).
- start_i in ARMED or SHIFT is ignored: no re-capture, frame unaffected, overrun_o=1 for that cycle.
- start_i in the same cycle as the final FALL (done_o cycle): the new start is accepted. Capture, go directly to ARMED, busy_o stays 1, overrun_o=0. The next frame begins on the next FALL.
- Reset mid-frame: all outputs return to reset values on the next clock edge. No partial frame resumes. The divider restarts with dclk_o=0.
- Inputs ch*_i may change freely after the accepting cycle.

Test Plan:
- Reset check: hold reset 5 cycles, then release with start_i=0 -> all outputs 0 during reset. After release, dclk_o toggles every 4 cycles; drdy_o and din*_o stay 0 and busy_o stays 0 for 1000 cycles.
- Single frame, HALF_DIV=4:
  - Stimulus: ch1=24'h123456, ch2=24'hFEDCBA, ch3..ch8=24'h800000+idx, one start_i pulse.
  - Lane0, sampled on dclk rising edges from drdy rise, reads 64'h00123456_01FEDCBA.
  - Lane1 reads 64'h02800002_03800003.
  - drdy_o is high exactly 8 cycles. done_o pulses once, 512 cycles after drdy rise.
- Overrun: issue start_i again 100 cycles after the first accept -> overrun_o pulses in that cycle. The frame data is unchanged; done_o pulses exactly once.
- Back-to-back: assert start_i in the done_o cycle with new ch1=24'h000001 -> busy_o never drops. The second frame's drdy rises within 8 cycles, and lane0 word0 is 32'h00000001.
- Reset mid-frame: assert reset at bit 20 of a frame -> next cycle all outputs are 0 and done_o never pulses. A subsequent start_i produces a complete, correct frame.
- HALF_DIV=1 build: run the single-frame stimulus -> dclk_o = clk_i/2 and lane0 bits are identical to the default case. Frame length is 128 cycles.

Source files
------------

// File: rtl/dout_emulator_if.sv
// Parallel side of the ADC data-output emulator: frame request, eight channel
// samples, and the serial lanes plus status flags it produces.
interface dout_emulator_if;
    logic        start_i;
    logic [23:0] ch1_i, ch2_i, ch3_i, ch4_i, ch5_i, ch6_i, ch7_i, ch8_i;
    logic        dclk_o;
    logic        drdy_o;
    logic        din0_o, din1_o, din2_o, din3_o;
    logic        busy_o;
    logic        done_o;
    logic        overrun_o;

    modport master (
        output start_i, ch1_i, ch2_i, ch3_i, ch4_i, ch5_i, ch6_i, ch7_i, ch8_i,
        input  dclk_o, drdy_o, din0_o, din1_o, din2_o, din3_o, busy_o, done_o, overrun_o
    );

    modport slave (
        input  start_i, ch1_i, ch2_i, ch3_i, ch4_i, ch5_i, ch6_i, ch7_i, ch8_i,
        output dclk_o, drdy_o, din0_o, din1_o, din2_o, din3_o, busy_o, done_o, overrun_o
    );
endinterface

// File: rtl/dout_emulator.sv
// ADC data-output emulator: serialises eight 24-bit samples onto four lanes as
// one drdy-framed burst, bits changing only on dclk falling edges.
module dout_emulator #(
    parameter int HALF_DIV  = 4,
    parameter int SLOT_BITS = 32
) (
    input  logic           clk_i,
    input  logic           reset,
    dout_emulator_if.slave bus
);
    localparam int CNT_W     = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam int LANE_BITS = 2 * SLOT_BITS;
    localparam int N_LANES   = 4;

    typedef enum logic [1:0] {IDLE, ARMED, SHIFT} state_t;

    logic [CNT_W-1:0]     cnt_reg;
    logic                 dclk_reg;
    logic                 tick;
    logic                 fall;
    logic [23:0]          ch_arr    [2*N_LANES];
    logic [LANE_BITS-1:0] load_word [N_LANES];
    logic [LANE_BITS-1:0] lane_reg  [N_LANES];
    logic [N_LANES-1:0]   din_reg;
    logic                 drdy_reg;
    logic                 busy_reg;
    logic                 done_reg;
    logic                 overrun_reg;
    logic [5:0]           bit_cnt_reg;
    state_t               state_reg;
    logic                 last_fall;

    assign ch_arr[0] = bus.ch1_i;
    assign ch_arr[1] = bus.ch2_i;
    assign ch_arr[2] = bus.ch3_i;
    assign ch_arr[3] = bus.ch4_i;
    assign ch_arr[4] = bus.ch5_i;
    assign ch_arr[5] = bus.ch6_i;
    assign ch_arr[6] = bus.ch7_i;
    assign ch_arr[7] = bus.ch8_i;

    // Each lane carries two consecutive channels, each tagged with its index.
    generate
        for (genvar gi = 0; gi < N_LANES; gi++) begin : g_lane
            assign load_word[gi] = {5'b00000, 3'(2*gi),     ch_arr[2*gi],
                                    5'b00000, 3'(2*gi + 1), ch_arr[2*gi + 1]};
        end
    endgenerate

    assign tick      = (cnt_reg == CNT_W'(HALF_DIV - 1));
    assign fall      = dclk_reg && tick;
    assign last_fall = (state_reg == SHIFT) && fall && (bit_cnt_reg == 6'(LANE_BITS - 1));

    // Free-running divider; dclk keeps toggling even with no frame pending.
    always_ff @(posedge clk_i) begin
        if (reset) begin
            cnt_reg  <= '0;
            dclk_reg <= 1'b0;
        end else if (tick) begin
            cnt_reg  <= '0;
            dclk_reg <= ~dclk_reg;
        end else begin
            cnt_reg  <= cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset) begin
            state_reg   <= IDLE;
            din_reg     <= '0;
            drdy_reg    <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            overrun_reg <= 1'b0;
            bit_cnt_reg <= '0;
            for (int i = 0; i < N_LANES; i++) lane_reg[i] <= '0;
        end else begin
            done_reg    <= 1'b0;
            overrun_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.start_i) begin
                        for (int i = 0; i < N_LANES; i++) lane_reg[i] <= load_word[i];
                        busy_reg  <= 1'b1;
                        state_reg <= ARMED;
                    end
                end
                ARMED: begin
                    if (bus.start_i) overrun_reg <= 1'b1;
                    if (fall) begin
                        for (int i = 0; i < N_LANES; i++) din_reg[i] <= lane_reg[i][LANE_BITS-1];
                        drdy_reg    <= 1'b1;
                        bit_cnt_reg <= '0;
                        state_reg   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (bus.start_i && !last_fall) overrun_reg <= 1'b1;
                    if (last_fall) begin
                        din_reg  <= '0;
                        drdy_reg <= 1'b0;
                        done_reg <= 1'b1;
                        // A start landing on the final edge chains straight into the next frame.
                        if (bus.start_i) begin
                            for (int i = 0; i < N_LANES; i++) lane_reg[i] <= load_word[i];
                            state_reg <= ARMED;
                        end else begin
                            busy_reg  <= 1'b0;
                            state_reg <= IDLE;
                        end
                    end else if (fall) begin
                        for (int i = 0; i < N_LANES; i++) begin
                            din_reg[i]  <= lane_reg[i][LANE_BITS-2];
                            lane_reg[i] <= {lane_reg[i][LANE_BITS-2:0], 1'b0};
                        end
                        drdy_reg    <= 1'b0;
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.dclk_o    = dclk_reg;
    assign bus.drdy_o    = drdy_reg;
    assign bus.din0_o    = din_reg[0];
    assign bus.din1_o    = din_reg[1];
    assign bus.din2_o    = din_reg[2];
    assign bus.din3_o    = din_reg[3];
    assign bus.busy_o    = busy_reg;
    assign bus.done_o    = done_reg;
    assign bus.overrun_o = overrun_reg;
endmodule

// File: tb/tb_dout_emulator.sv
// Bench for dout_emulator: HALF_DIV=4 and HALF_DIV=1 instances share stimulus; each
// is checked every cycle against a time-based frame model plus literal frame pins.
module tb_dout_emulator;
    localparam int NI = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [23:0] ch [8];
    int          lit_checks = 0;
    int          lit_fails  = 0;

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < NI; gi++) begin : g_inst
            localparam int H = (gi == 0) ? 4 : 1;

            dout_emulator_if bus();
            // o = {dclk, drdy, din3, din2, din1, din0, busy, done, overrun}
            logic [8:0] o;
            int         checks = 0;
            int         fails  = 0;

            assign bus.start_i = start;
            assign bus.ch1_i   = ch[0];
            assign bus.ch2_i   = ch[1];
            assign bus.ch3_i   = ch[2];
            assign bus.ch4_i   = ch[3];
            assign bus.ch5_i   = ch[4];
            assign bus.ch6_i   = ch[5];
            assign bus.ch7_i   = ch[6];
            assign bus.ch8_i   = ch[7];

            dout_emulator #(.HALF_DIV(H), .SLOT_BITS(32)) dut (
                .clk_i (clk),
                .reset (reset),
                .bus   (bus)
            );

            assign o = {bus.dclk_o, bus.drdy_o, bus.din3_o, bus.din2_o, bus.din1_o,
                        bus.din0_o, bus.busy_o, bus.done_o, bus.overrun_o};

            task automatic pin(input string nm, input logic [63:0] got, input logic [63:0] want);
                checks++;
                if (got !== want) begin
                    fails++;
                    $display("FAIL %s (HALF_DIV=%0d) got=%h want=%h", nm, H, got, want);
                end
            endtask

            // Model: edge count n since reset; a frame accepted at edge a starts at the
            // next multiple of 2H, each bit lasts 2H edges, done lands 128H edges later.
            longint      n;
            bit          act;
            longint      f0;
            logic [63:0] word [4];
            logic [8:0]  exp_o;
            bit          ending;
            bit          ovr;
            longint      j;
            int          frame_idx;
            bit          cap;
            int          cap_bit;
            int          drdy_len;
            longint      rise_n;
            logic [63:0] cap_l0, cap_l1;
            logic        prev_dclk, prev_drdy;

            initial begin
                n = 0; act = 0; f0 = 0; frame_idx = 0; cap = 0; cap_bit = 0;
                drdy_len = 0; rise_n = 0; cap_l0 = '0; cap_l1 = '0;
                prev_dclk = 1'b0; prev_drdy = 1'b0;
                forever begin
                    @(posedge clk);
                    exp_o = '0;
                    if (reset) begin
                        n   = 0;
                        act = 0;
                    end else begin
                        n++;
                        ending = act && (n == f0 + 128 * H);
                        if (ending) act = 0;
                        ovr = 0;
                        if (start) begin
                            if (!act) begin
                                act = 1;
                                f0  = (n / (2 * H) + 1) * (2 * H);
                                for (int l = 0; l < 4; l++)
                                    word[l] = {8'(2*l), ch[2*l], 8'(2*l + 1), ch[2*l + 1]};
                            end else begin
                                ovr = 1;
                            end
                        end
                        exp_o[8] = ((n / H) % 2) == 1;
                        exp_o[2] = act;
                        exp_o[1] = ending;
                        exp_o[0] = ovr;
                        if (act && n >= f0) begin
                            j = (n - f0) / (2 * H);
                            exp_o[7] = (j == 0);
                            for (int l = 0; l < 4; l++) exp_o[3 + l] = word[l][63 - j];
                        end
                    end
                    #1;
                    checks++;
                    if (o !== exp_o) begin
                        fails++;
                        $display("FAIL outputs (HALF_DIV=%0d) edge=%0d got=%b want=%b", H, n, o, exp_o);
                    end

                    // Literal pins: recover lane words at dclk rising edges from drdy rise.
                    if (reset) begin
                        cap = 0;
                    end else begin
                        if (o[7] && !prev_drdy) begin
                            cap = 1; cap_bit = 0; drdy_len = 0; rise_n = n;
                            cap_l0 = '0; cap_l1 = '0;
                        end
                        if (cap && o[7]) drdy_len++;
                        if (cap && o[8] && !prev_dclk) begin
                            cap_l0 = {cap_l0[62:0], o[3]};
                            cap_l1 = {cap_l1[62:0], o[4]};
                            cap_bit++;
                        end
                        if (cap && o[1]) begin
                            if (frame_idx == 0) begin
                                pin("frame0_lane0", cap_l0, 64'h00123456_01FEDCBA);
                                pin("frame0_lane1", cap_l1, 64'h02800002_03800003);
                                pin("frame0_drdy_len", 64'(drdy_len), 64'(2 * H));
                                pin("frame0_length", 64'(n - rise_n), 64'(128 * H));
                                pin("frame0_bits", 64'(cap_bit), 64'd64);
                            end else if (frame_idx == 1) begin
                                pin("overrun_frame_lane0", cap_l0, 64'h00123456_01FEDCBA);
                            end else if (frame_idx == 2) begin
                                pin("b2b_word0", {32'h0, cap_l0[63:32]}, 64'h00000001);
                            end
                            frame_idx++;
                            cap = 0;
                        end
                    end
                    prev_dclk = o[8];
                    prev_drdy = o[7];
                end
            end
        end
    endgenerate

    task automatic step();
        @(negedge clk);
    endtask

    task automatic lit(input string nm, input logic [63:0] got, input logic [63:0] want);
        lit_checks++;
        if (got !== want) begin
            lit_fails++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    task automatic wait_done(input string nm, input int bound);
        int c = 0;
        while (!g_inst[0].o[1] && c < bound) begin
            step();
            c++;
        end
        lit(nm, 64'(g_inst[0].o[1]), 64'd1);
    endtask

    task automatic wait_drdy(input string nm, input int bound, output int c);
        c = 0;
        while (!g_inst[0].o[7] && c < bound) begin
            step();
            c++;
        end
        lit(nm, 64'(g_inst[0].o[7]), 64'd1);
    endtask

    task automatic set_frame_a();
        ch[0] = 24'h123456;
        ch[1] = 24'hFEDCBA;
        for (int k = 2; k < 8; k++) ch[k] = 24'h800000 + 24'(k);
    endtask

    task automatic rand_ch();
        for (int k = 0; k < 8; k++) ch[k] = 24'($urandom);
    endtask

    int off, rise, c, done_cnt, gap, len, rst_at, total, failed;
    bit busy_ok, do_rst;

    initial begin
        reset = 1'b1;
        start = 1'b0;
        for (int k = 0; k < 8; k++) ch[k] = '0;

        repeat (5) step();
        lit("reset_outputs_h4", {55'h0, g_inst[0].o}, 64'h0);
        lit("reset_outputs_h1", {55'h0, g_inst[1].o}, 64'h0);
        reset = 1'b0;
        repeat (1000) step();
        lit("idle_quiet", {58'h0, g_inst[0].o[7:2]}, 64'h0);

        // Frame A: reference data.
        set_frame_a();
        start = 1'b1; step(); start = 1'b0;
        wait_done("frame_a_done", 2000);
        $display("frame A complete at %0t", $time);

        // Frame B: second start 100 edges after acceptance, then chain on its done edge.
        step();
        start = 1'b1; step(); start = 1'b0;
        off = 0; rise = -1;
        while (off < 99) begin
            step(); off++;
            if (g_inst[0].o[7] && rise < 0) rise = off;
        end
        lit("arm_latency", 64'(rise >= 1 && rise <= 8), 64'd1);
        if (rise < 1) rise = 1;
        ch[0] = 24'hABCDEF;
        start = 1'b1; step(); off++; start = 1'b0;
        lit("overrun_pulse", 64'(g_inst[0].o[0]), 64'd1);
        lit("overrun_busy", 64'(g_inst[0].o[2]), 64'd1);
        while (off < rise + 511) begin
            step(); off++;
        end
        ch[0] = 24'h000001;
        start = 1'b1; step(); start = 1'b0;
        lit("b2b_done", 64'(g_inst[0].o[1]), 64'd1);
        lit("b2b_busy", 64'(g_inst[0].o[2]), 64'd1);
        $display("frame B complete at %0t, chained start issued", $time);

        // Frame C: must arm within 2*HALF_DIV cycles without busy dropping.
        c = 0; busy_ok = 1;
        while (!g_inst[0].o[7] && c < 20) begin
            step(); c++;
            if (!g_inst[0].o[2]) busy_ok = 0;
        end
        lit("b2b_latency", 64'(c >= 1 && c <= 8), 64'd1);
        lit("b2b_busy_held", 64'(busy_ok), 64'd1);
        wait_done("frame_c_done", 2000);
        $display("frame C complete at %0t", $time);

        // Frame D: reset during bit 20.
        step();
        rand_ch();
        start = 1'b1; step(); start = 1'b0;
        wait_drdy("frame_d_drdy", 20, c);
        repeat (163) step();
        reset = 1'b1; step();
        lit("reset_midframe", {55'h0, g_inst[0].o}, 64'h0);
        step(); reset = 1'b0;
        done_cnt = 0;
        for (int k = 0; k < 600; k++) begin
            step();
            if (g_inst[0].o[1]) done_cnt++;
        end
        lit("no_done_after_reset", 64'(done_cnt), 64'd0);
        $display("frame D aborted by reset at %0t", $time);

        // Frame E: full frame after the aborted one.
        set_frame_a();
        start = 1'b1; step(); start = 1'b0;
        wait_done("frame_e_done", 2000);
        $display("frame E complete at %0t", $time);

        // Random traffic: samples change every cycle, stray starts, occasional resets.
        for (int it = 0; it < 25; it++) begin
            gap = $urandom_range(0, 40);
            repeat (gap) begin rand_ch(); step(); end
            rand_ch();
            start = 1'b1; step(); start = 1'b0;
            len    = $urandom_range(50, 700);
            do_rst = ($urandom_range(0, 7) == 0);
            rst_at = $urandom_range(0, len - 1);
            for (int k = 0; k < len; k++) begin
                rand_ch();
                start = ($urandom_range(0, 199) == 0);
                reset = do_rst && (k == rst_at);
                step();
            end
            start = 1'b0;
            reset = 1'b0;
            $display("random burst %0d: len=%0d reset=%0d", it, len, do_rst);
        end
        repeat (10) step();

        total  = lit_checks + g_inst[0].checks + g_inst[1].checks;
        failed = lit_fails + g_inst[0].fails + g_inst[1].fails;
        $display("%0d/%0d checks passed", total - failed, total);
        $finish;
    end
endmodule
